// File: rtl/button_conditioner.sv
// Pushbutton front end: per-key two-flop synchronizer and debounce FSM,
// one-cycle press events with processor-reset priority, synchronized switches.

module button_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_n,
  output logic accept,
  output logic held
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  logic             sync1, sync2;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  // Synchronizer resets to the released level so reset never looks like a press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!sync2) begin
          // With a single-sample window the first low sample is already stable.
          if (SINGLE) begin
            state_n = PRESSED;
            accept  = 1'b1;
          end else begin
            state_n = PRESS_WAIT;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (sync2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          accept  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        cnt_n = '0;
        if (sync2) begin
          if (SINGLE) begin
            state_n = IDLE;
          end else begin
            state_n = RELEASE_WAIT;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (!sync2) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      held  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      held  <= (state_n == PRESSED) || (state_n == RELEASE_WAIT);
    end
  end

endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Key_Run_n,
  input  logic       Key_ClearA_LoadB_n,
  input  logic       Key_Reset_n,
  input  logic [7:0] SW,
  output logic       Run_pulse,
  output logic       ClearA_LoadB_pulse,
  output logic       Reset_pulse,
  output logic [2:0] Held,
  output logic [7:0] S_sync
);

  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0] keys_n;
  logic [NUM_LANES-1:0] accept;
  logic [7:0]           sw_meta;

  assign keys_n = {Key_Reset_n, Key_ClearA_LoadB_n, Key_Run_n};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .Clk   (Clk),
      .Reset (Reset),
      .key_n (keys_n[i]),
      .accept(accept[i]),
      .held  (Held[i])
    );
  end

  // A processor reset accepted in the same cycle swallows Run/ClearA_LoadB events.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Run_pulse          <= 1'b0;
      ClearA_LoadB_pulse <= 1'b0;
      Reset_pulse        <= 1'b0;
    end else begin
      Reset_pulse        <= accept[2];
      ClearA_LoadB_pulse <= accept[1] & ~accept[2];
      Run_pulse          <= accept[0] & ~accept[2];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sw_meta <= 8'h00;
      S_sync  <= 8'h00;
    end else begin
      sw_meta <= SW;
      S_sync  <= sw_meta;
    end
  end

endmodule
